// File: rtl/spi_frame_loader.sv
// Double-buffered frame store fed by SPI bytes: command decode per chip-select
// transaction, pixel writes to the back bank, and a bank swap taken only at vblank.
module spi_frame_loader #(
    parameter int         ADDR_WIDTH = 11,
    parameter int         DEPTH      = 1536,
    parameter logic [7:0] CMD_WRITE  = 8'h01,
    parameter logic [7:0] CMD_CLEAR  = 8'h02,
    parameter logic [7:0] CMD_SWAP   = 8'h03
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  vblank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  display_en,
    output logic                  busy,
    output logic [7:0]            frame_count,
    output logic                  err_overrun,
    output logic                  err_cmd
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_CLEAR_ARG,
        ST_CLEAR,
        ST_SWAP_WAIT,
        ST_DROP
    } state_t;

    state_t             state_q, state_d;
    logic               cs_sync1_q, cs_sync2_q, cs_prev_q;
    logic               disp_bank_q, disp_bank_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]         fill_q, fill_d;
    logic               display_en_q, display_en_d;
    logic [7:0]         frame_count_q, frame_count_d;
    logic               err_overrun_q, err_overrun_d;
    logic               err_cmd_q, err_cmd_d;
    logic [7:0]         rd_data_q, rd_data_d;

    logic               cs_fall, cs_rise;
    logic               mem_we;
    logic [ADDR_WIDTH:0] mem_waddr;
    logic [7:0]         mem_wdata;
    logic               rd_in_range;

    // Both banks share one array; the top address bit selects the bank.
    logic [7:0] mem [0:(2**(ADDR_WIDTH+1))-1];

    assign cs_fall     = cs_prev_q & ~cs_sync2_q;
    assign cs_rise     = ~cs_prev_q & cs_sync2_q;
    assign mem_waddr   = {~disp_bank_q, wr_ptr_q[ADDR_WIDTH-1:0]};
    assign rd_in_range = ({1'b0, rd_addr} < PTR_W'(DEPTH));

    always_comb begin
        state_d       = state_q;
        disp_bank_d   = disp_bank_q;
        wr_ptr_d      = wr_ptr_q;
        fill_d        = fill_q;
        display_en_d  = display_en_q;
        frame_count_d = frame_count_q;
        err_overrun_d = 1'b0;
        err_cmd_d     = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = rx_data;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE) begin
                        state_d  = ST_WRITE;
                        wr_ptr_d = '0;
                    end else if (rx_data == CMD_CLEAR) begin
                        state_d = ST_CLEAR_ARG;
                    end else if (rx_data == CMD_SWAP) begin
                        state_d = ST_SWAP_WAIT;
                    end else begin
                        state_d   = ST_DROP;
                        err_cmd_d = 1'b1;
                    end
                end
                if (cs_rise) state_d = ST_IDLE;
            end
            ST_WRITE: begin
                if (rx_valid) begin
                    if (wr_ptr_q < PTR_W'(DEPTH)) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end
                if (cs_rise) state_d = ST_IDLE;
            end
            ST_CLEAR_ARG: begin
                if (rx_valid) begin
                    fill_d   = rx_data;
                    wr_ptr_d = '0;
                    state_d  = ST_CLEAR;
                end
                if (cs_rise) state_d = ST_IDLE;
            end
            // Runs to completion regardless of chip select; stray bytes are rejected.
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = fill_q;
                err_cmd_d = rx_valid;
                if (wr_ptr_q == PTR_W'(DEPTH - 1)) state_d = ST_IDLE;
                else wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            ST_SWAP_WAIT: begin
                err_cmd_d = rx_valid;
                if (vblank) begin
                    disp_bank_d   = ~disp_bank_q;
                    display_en_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (cs_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        rd_data_d = (display_en_q && rd_in_range) ? mem[{disp_bank_q, rd_addr}] : 8'h00;
    end

    // Synchroniser flops idle high so a released chip select never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cs_sync1_q    <= 1'b1;
            cs_sync2_q    <= 1'b1;
            cs_prev_q     <= 1'b1;
            disp_bank_q   <= 1'b0;
            wr_ptr_q      <= '0;
            fill_q        <= 8'h00;
            display_en_q  <= 1'b0;
            frame_count_q <= 8'h00;
            err_overrun_q <= 1'b0;
            err_cmd_q     <= 1'b0;
            rd_data_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            cs_sync1_q    <= cs_n;
            cs_sync2_q    <= cs_sync1_q;
            cs_prev_q     <= cs_sync2_q;
            disp_bank_q   <= disp_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_q        <= fill_d;
            display_en_q  <= display_en_d;
            frame_count_q <= frame_count_d;
            err_overrun_q <= err_overrun_d;
            err_cmd_q     <= err_cmd_d;
            rd_data_q     <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && rst_n) mem[mem_waddr] <= mem_wdata;
    end

    assign rd_data     = rd_data_q;
    assign display_en  = display_en_q;
    assign busy        = (state_q == ST_CLEAR) || (state_q == ST_SWAP_WAIT);
    assign frame_count = frame_count_q;
    assign err_overrun = err_overrun_q;
    assign err_cmd     = err_cmd_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader using a small 8-byte frame so whole banks
// can be written, cleared and read back quickly.
module tb_spi_frame_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          vblank;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          display_en;
    logic          busy;
    logic [7:0]    frame_count;
    logic          err_overrun;
    logic          err_cmd;

    int tests_run    = 0;
    int tests_failed = 0;
    int err_cmd_cnt  = 0;
    int err_ovr_cnt  = 0;
    int busy_cnt     = 0;

    spi_frame_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .vblank(vblank), .rd_addr(rd_addr), .rd_data(rd_data), .display_en(display_en),
        .busy(busy), .frame_count(frame_count), .err_overrun(err_overrun), .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    // Pulse and busy-cycle counters sampled mid-cycle.
    always @(negedge clk) begin
        if (err_cmd === 1'b1) err_cmd_cnt++;
        if (err_overrun === 1'b1) err_ovr_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk) cs_n = 1'b0;
        idle(4);
    endtask

    task automatic cs_high();
        @(negedge clk) cs_n = 1'b1;
        idle(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_vblank();
        @(negedge clk) vblank = 1'b1;
        @(negedge clk) vblank = 1'b0;
    endtask

    task automatic do_swap();
        cs_low();
        send_byte(8'h03);
        pulse_vblank();
        cs_high();
    endtask

    task automatic read_at(input logic [AW-1:0] a, output logic [7:0] v);
        @(negedge clk) rd_addr = a;
        @(negedge clk) v = rd_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0; cs_n = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; vblank = 1'b0; rd_addr = '0;
        idle(3);
        rst_n = 1'b1;
        tests_run++;
        if ({display_en, busy, frame_count, err_overrun, err_cmd, rd_data} !== 20'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got en=%b busy=%b fc=%h ovr=%b cmd=%b rd=%h, want all 0",
                     display_en, busy, frame_count, err_overrun, err_cmd, rd_data);
        end
        read_at(0, v);
        tests_run++;
        if (v !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_read_gated: got %h want 00", v);
        end
    endtask

    task automatic test_clear();
        logic [7:0] v;
        cs_low();
        send_byte(8'h02);
        busy_cnt = 0; err_cmd_cnt = 0;
        send_byte(8'hE0);
        send_byte(8'h77);
        idle(12);
        tests_run++;
        if (busy_cnt !== DEPTH) begin
            tests_failed++;
            $display("[TB] FAIL clear_busy_cycles: got %0d want %0d", busy_cnt, DEPTH);
        end
        tests_run++;
        if (err_cmd_cnt !== 1) begin
            tests_failed++;
            $display("[TB] FAIL clear_err_cmd: got %0d pulses want 1", err_cmd_cnt);
        end
        cs_high();
        cs_low();
        send_byte(8'h03);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL swap_busy: got %b want 1", busy);
        end
        pulse_vblank();
        tests_run++;
        if (display_en !== 1'b1 || frame_count !== 8'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL first_swap: got en=%b fc=%0d busy=%b want 1/1/0", display_en, frame_count, busy);
        end
        cs_high();
        for (int i = 0; i < DEPTH; i++) begin
            read_at(AW'(i), v);
            tests_run++;
            if (v !== 8'hE0) begin
                tests_failed++;
                $display("[TB] FAIL clear_data[%0d]: got %h want E0", i, v);
            end
        end
        read_at(AW'(DEPTH), v);
        tests_run++;
        if (v !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL read_beyond_depth: got %h want 00", v);
        end
    endtask

    task automatic test_write_swap();
        logic [7:0] v;
        logic [7:0] exp [0:4];
        exp[0] = 8'hAA; exp[1] = 8'hBB; exp[2] = 8'hCC; exp[3] = 8'hDD; exp[4] = 8'h5A;
        cs_low();
        send_byte(8'h02);
        send_byte(8'h5A);
        idle(10);
        cs_high();
        cs_low();
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(exp[i]);
        cs_high();
        read_at(0, v);
        tests_run++;
        if (v !== 8'hE0) begin
            tests_failed++;
            $display("[TB] FAIL front_stable: got %h want E0", v);
        end
        do_swap();
        tests_run++;
        if (frame_count !== 8'd2) begin
            tests_failed++;
            $display("[TB] FAIL write_frame_count: got %0d want 2", frame_count);
        end
        for (int i = 0; i < 5; i++) begin
            read_at(AW'(i), v);
            tests_run++;
            if (v !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL write_data[%0d]: got %h want %h", i, v, exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        err_ovr_cnt = 0;
        cs_low();
        send_byte(8'h01);
        for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i));
        idle(2);
        cs_high();
        tests_run++;
        if (err_ovr_cnt !== 2) begin
            tests_failed++;
            $display("[TB] FAIL overrun_pulses: got %0d want 2", err_ovr_cnt);
        end
        do_swap();
        for (int i = 0; i < DEPTH; i++) begin
            read_at(AW'(i), v);
            tests_run++;
            if (v !== 8'h10 + 8'(i)) begin
                tests_failed++;
                $display("[TB] FAIL overrun_data[%0d]: got %h want %h", i, v, 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_swap_wait();
        logic [7:0] v;
        cs_low();
        @(negedge clk);
        rx_data = 8'h03; rx_valid = 1'b1; vblank = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; vblank = 1'b0;
        cs_high();
        idle(1000);
        tests_run++;
        if (busy !== 1'b1 || frame_count !== 8'd3) begin
            tests_failed++;
            $display("[TB] FAIL swap_pending: got busy=%b fc=%0d want 1/3", busy, frame_count);
        end
        read_at(0, v);
        tests_run++;
        if (v !== 8'h10) begin
            tests_failed++;
            $display("[TB] FAIL swap_pending_front: got %h want 10", v);
        end
        pulse_vblank();
        tests_run++;
        if (busy !== 1'b0 || frame_count !== 8'd4) begin
            tests_failed++;
            $display("[TB] FAIL swap_taken: got busy=%b fc=%0d want 0/4", busy, frame_count);
        end
        read_at(0, v);
        tests_run++;
        if (v !== 8'hAA) begin
            tests_failed++;
            $display("[TB] FAIL swap_taken_front: got %h want AA", v);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] v;
        err_cmd_cnt = 0;
        cs_low();
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'h55);
        idle(2);
        tests_run++;
        if (err_cmd_cnt !== 1) begin
            tests_failed++;
            $display("[TB] FAIL bad_cmd_pulses: got %0d want 1", err_cmd_cnt);
        end
        cs_high();
        do_swap();
        read_at(0, v);
        tests_run++;
        if (v !== 8'h10 || frame_count !== 8'd5) begin
            tests_failed++;
            $display("[TB] FAIL bad_cmd_no_write: got %h fc=%0d want 10 fc=5", v, frame_count);
        end
        cs_low();
        send_byte(8'h01);
        send_byte(8'h55);
        cs_high();
        do_swap();
        read_at(0, v);
        tests_run++;
        if (v !== 8'h55) begin
            tests_failed++;
            $display("[TB] FAIL recover_write0: got %h want 55", v);
        end
        read_at(1, v);
        tests_run++;
        if (v !== 8'hBB) begin
            tests_failed++;
            $display("[TB] FAIL recover_write1: got %h want BB", v);
        end
    endtask

    task automatic test_reset_mid();
        cs_low();
        send_byte(8'h01);
        send_byte(8'h99);
        @(negedge clk);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({display_en, busy, frame_count, err_overrun, err_cmd, rd_data} !== 20'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: got en=%b busy=%b fc=%h ovr=%b cmd=%b rd=%h, want all 0",
                     display_en, busy, frame_count, err_overrun, err_cmd, rd_data);
        end
        rst_n = 1'b1;
        idle(4);
        err_cmd_cnt = 0;
        send_byte(8'h42);
        idle(2);
        tests_run++;
        if (err_cmd_cnt !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_idle: got errs=%0d busy=%b want 0/0", err_cmd_cnt, busy);
        end
        cs_low();
        send_byte(8'h03);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_restart: got busy=%b want 1", busy);
        end
        cs_high();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_swap();
        test_overrun();
        test_swap_wait();
        test_bad_cmd();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
